data_array_ctrl: RTL and testbench

//  Port sequencer/arbiter for the 4-way L1 data blockram (1R1W, 128b write, 4x128b read).

---
 rtl/data_array_pkg.sv | 36 +++
 rtl/data_evict_seq.sv | 110 +++++++++++
 rtl/data_array_ctrl.sv | 143 ++++++++++++++
 tb/tb_data_array_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_array_pkg.sv
// Shared definitions for the L1 data-array port sequencer.
// Contents: geometry constants, quarter/line types, blockram address
// packing helpers and the state encodings of the fill and evict FSMs.
package data_array_pkg;

   localparam int SET_W     = 8;                    // 256 sets
   localparam int WAY_W     = 2;                    // 4 ways
   localparam int Q_W       = 2;                    // 4 quarters per line
   localparam int QW        = 128;                  // quarter-line width
   localparam int LINE_W    = 4 * QW;               // full line width
   localparam int RD_ADDR_W = SET_W + Q_W;          // {set,q}
   localparam int WR_ADDR_W = SET_W + Q_W + WAY_W;  // {set,q,way}

   typedef logic [QW-1:0]        quarter_t;
   typedef logic [LINE_W-1:0]    line_t;
   typedef logic [SET_W-1:0]     set_t;
   typedef logic [WAY_W-1:0]     way_t;
   typedef logic [Q_W-1:0]       qidx_t;
   typedef logic [RD_ADDR_W-1:0] rd_addr_t;
   typedef logic [WR_ADDR_W-1:0] wr_addr_t;

   // Last quarter of a line; reaching it ends a fill or read phase.
   localparam qidx_t Q_LAST = '1;

   typedef enum logic       {F_IDLE, F_WR}                 fill_state_t;
   typedef enum logic [1:0] {E_IDLE, E_RD, E_WAIT, E_OUT}  ev_state_t;

   function automatic wr_addr_t pack_wr_addr(set_t set, qidx_t q, way_t way);
      return {set, q, way};
   endfunction

   function automatic rd_addr_t pack_rd_addr(set_t set, qidx_t q);
      return {set, q};
   endfunction

endpackage

// File: rtl/data_evict_seq.sv
// Victim eviction sequencer and blockram read-port mux.
// Accepts an evict request, reads the victim line as four quarter reads
// (one per cycle), reassembles it in a line buffer and presents it until
// the consumer takes it.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   ev_req_valid/ev_req_ready       evict request handshake
//   ev_set, ev_way                  victim line
//   ev_data_valid/ev_data_ready     assembled line handshake
//   ev_data                         assembled victim line
//   cpu_rd_valid, cpu_rd_addr       CPU lookup read request
//   bram_rd_addr                    blockram read address (muxed)
//   bram_data_out                   blockram read data, 1-cycle latency
//   rd_phase                        evict owns the read port this cycle
//   busy                            evict in read or wait phase
//   cur_set, cur_way                line currently being evicted
module data_evict_seq
   import data_array_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ev_req_valid,
   output logic                 ev_req_ready,
   input  logic [SET_W-1:0]     ev_set,
   input  logic [WAY_W-1:0]     ev_way,
   output logic                 ev_data_valid,
   input  logic                 ev_data_ready,
   output logic [LINE_W-1:0]    ev_data,
   input  logic                 cpu_rd_valid,
   input  logic [RD_ADDR_W-1:0] cpu_rd_addr,
   output logic [RD_ADDR_W-1:0] bram_rd_addr,
   input  logic [LINE_W-1:0]    bram_data_out,
   output logic                 rd_phase,
   output logic                 busy,
   output logic [SET_W-1:0]     cur_set,
   output logic [WAY_W-1:0]     cur_way
);

   ev_state_t state, state_nxt;
   qidx_t     q;        // quarter being read this cycle
   qidx_t     cap_q;    // quarter whose data arrives this cycle
   logic      cap_en;   // a read was issued last cycle
   line_t     line_buf;

   // NOTE: every output of a combinational block gets a default first, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt     = state;
      ev_req_ready  = 1'b0;
      ev_data_valid = 1'b0;
      unique case (state)
         E_IDLE: begin
            ev_req_ready = 1'b1;
            if (ev_req_valid) state_nxt = E_RD;
         end
         E_RD:   if (q == Q_LAST) state_nxt = E_WAIT;
         E_WAIT: state_nxt = E_OUT;
         E_OUT: begin
            ev_data_valid = 1'b1;
            if (ev_data_ready) state_nxt = E_IDLE;
         end
         default: state_nxt = E_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the values from before the clock edge.
   // NOTE: the line buffer is reset because ev_data must read 0 out of
   // reset and a partially gathered line must never leak after an abort.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= E_IDLE;
         q        <= '0;
         cap_q    <= '0;
         cap_en   <= 1'b0;
         cur_set  <= '0;
         cur_way  <= '0;
         line_buf <= '0;
      end else begin
         state  <= state_nxt;
         cap_en <= (state == E_RD);
         cap_q  <= q;
         if (state == E_IDLE && ev_req_valid) begin
            cur_set <= ev_set;
            cur_way <= ev_way;
            q       <= '0;
         end else if (state == E_RD) begin
            q <= q + 1'b1;   // wraps 3->0 as the read phase ends
         end
         // Data for the quarter read last cycle; the q3 capture lands in E_WAIT.
         if (cap_en)
            line_buf[cap_q*QW +: QW] <= bram_data_out[cur_way*QW +: QW];
      end
   end

   assign rd_phase = (state == E_RD);
   assign busy     = (state == E_RD) || (state == E_WAIT);
   assign ev_data  = line_buf;

   // Idle read address is parked at 0 so the blockram address bus only
   // toggles for real lookups.
   always_comb begin
      bram_rd_addr = '0;
      if (rd_phase)
         bram_rd_addr = pack_rd_addr(cur_set, q);
      else if (cpu_rd_valid)
         bram_rd_addr = cpu_rd_addr;
   end

endmodule

// File: rtl/data_array_ctrl.sv
// Port sequencer/arbiter for the 4-way L1 data blockram (1R1W).
// Write port: shared between 128b stores (pass-through) and 512b line
// fills written as four quarter beats. Read port: shared between CPU
// lookups and victim eviction (see data_evict_seq).
// Ports:
//   fill_valid/ready, fill_set, fill_way, fill_data, fill_done   line fill
//   st_valid/ready, st_addr {set,q,way}, st_data                 store
//   cpu_rd_valid/ready, cpu_rd_addr {set,q}                      lookup
//   ev_req_valid/ready, ev_set, ev_way                           evict request
//   ev_data_valid/ready, ev_data                                 victim line
//   bram_rd_addr, bram_wr_addr, bram_wr_data, bram_wr_en,
//   bram_data_out                                                blockram side
module data_array_ctrl
   import data_array_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 fill_valid,
   output logic                 fill_ready,
   input  logic [SET_W-1:0]     fill_set,
   input  logic [WAY_W-1:0]     fill_way,
   input  logic [LINE_W-1:0]    fill_data,
   output logic                 fill_done,
   input  logic                 st_valid,
   output logic                 st_ready,
   input  logic [WR_ADDR_W-1:0] st_addr,
   input  logic [QW-1:0]        st_data,
   input  logic                 cpu_rd_valid,
   output logic                 cpu_rd_ready,
   input  logic [RD_ADDR_W-1:0] cpu_rd_addr,
   input  logic                 ev_req_valid,
   output logic                 ev_req_ready,
   input  logic [SET_W-1:0]     ev_set,
   input  logic [WAY_W-1:0]     ev_way,
   output logic                 ev_data_valid,
   input  logic                 ev_data_ready,
   output logic [LINE_W-1:0]    ev_data,
   output logic [RD_ADDR_W-1:0] bram_rd_addr,
   output logic [WR_ADDR_W-1:0] bram_wr_addr,
   output logic [QW-1:0]        bram_wr_data,
   output logic                 bram_wr_en,
   input  logic [LINE_W-1:0]    bram_data_out
);

   fill_state_t fill_state, fill_state_nxt;
   qidx_t       fill_q;
   set_t        fill_set_r;
   way_t        fill_way_r;
   line_t       fill_buf;

   logic ev_rd_phase, ev_busy;
   set_t ev_cur_set;
   way_t ev_cur_way;

   data_evict_seq u_evict (
      .clk           (clk),
      .rst_n         (rst_n),
      .ev_req_valid  (ev_req_valid),
      .ev_req_ready  (ev_req_ready),
      .ev_set        (ev_set),
      .ev_way        (ev_way),
      .ev_data_valid (ev_data_valid),
      .ev_data_ready (ev_data_ready),
      .ev_data       (ev_data),
      .cpu_rd_valid  (cpu_rd_valid),
      .cpu_rd_addr   (cpu_rd_addr),
      .bram_rd_addr  (bram_rd_addr),
      .bram_data_out (bram_data_out),
      .rd_phase      (ev_rd_phase),
      .busy          (ev_busy),
      .cur_set       (ev_cur_set),
      .cur_way       (ev_cur_way)
   );

   // A fill must not overwrite a line the evictor is still reading, and on
   // a same-cycle tie for the same line the evict request wins.
   logic fill_conflict, fill_fire;
   assign fill_conflict =
      (ev_busy && ev_cur_set == fill_set && ev_cur_way == fill_way) ||
      (ev_req_ready && ev_req_valid && ev_set == fill_set && ev_way == fill_way);
   assign fill_ready = (fill_state == F_IDLE) && !fill_conflict;
   assign fill_fire  = fill_valid && fill_ready;
   assign fill_done  = (fill_state == F_WR) && (fill_q == Q_LAST);

   // Stores yield to any pending fill and to a line being evicted. The
   // rst_n term keeps nothing accepted while the block is held in reset.
   set_t st_set;
   way_t st_way;
   logic st_fire;
   assign st_set   = st_addr[WR_ADDR_W-1 -: SET_W];
   assign st_way   = st_addr[WAY_W-1:0];
   assign st_ready = rst_n && (fill_state == F_IDLE) && !fill_valid &&
                     !(ev_busy && st_set == ev_cur_set && st_way == ev_cur_way);
   assign st_fire  = st_valid && st_ready;

   assign cpu_rd_ready = rst_n && !ev_rd_phase;

   always_comb begin
      fill_state_nxt = fill_state;
      unique case (fill_state)
         F_IDLE:  if (fill_fire) fill_state_nxt = F_WR;
         F_WR:    if (fill_q == Q_LAST) fill_state_nxt = F_IDLE;
         default: fill_state_nxt = F_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_state <= F_IDLE;
         fill_q     <= '0;
         fill_set_r <= '0;
         fill_way_r <= '0;
         fill_buf   <= '0;
      end else begin
         fill_state <= fill_state_nxt;
         if (fill_fire) begin
            fill_set_r <= fill_set;
            fill_way_r <= fill_way;
            fill_buf   <= fill_data;
            fill_q     <= '0;
         end else if (fill_state == F_WR) begin
            fill_q <= fill_q + 1'b1;   // wraps 3->0 as the fill ends
         end
      end
   end

   // Write-port mux; st_ready excludes F_WR, so only one writer is active.
   always_comb begin
      bram_wr_en   = 1'b0;
      bram_wr_addr = '0;
      bram_wr_data = '0;
      if (fill_state == F_WR) begin
         bram_wr_en   = 1'b1;
         bram_wr_addr = pack_wr_addr(fill_set_r, fill_q, fill_way_r);
         bram_wr_data = fill_buf[fill_q*QW +: QW];
      end else if (st_fire) begin
         bram_wr_en   = 1'b1;
         bram_wr_addr = st_addr;
         bram_wr_data = st_data;
      end
   end

endmodule

// File: tb/tb_data_array_ctrl.sv
// Self-checking bench for data_array_ctrl: directed sequence with random
// data, a 1R1W blockram model and a per-line reference of array contents.
module tb_data_array_ctrl;
   import data_array_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 fill_valid = 1'b0;
   logic                 fill_ready;
   logic [SET_W-1:0]     fill_set = '0;
   logic [WAY_W-1:0]     fill_way = '0;
   logic [LINE_W-1:0]    fill_data = '0;
   logic                 fill_done;
   logic                 st_valid = 1'b0;
   logic                 st_ready;
   logic [WR_ADDR_W-1:0] st_addr = '0;
   logic [QW-1:0]        st_data = '0;
   logic                 cpu_rd_valid = 1'b0;
   logic                 cpu_rd_ready;
   logic [RD_ADDR_W-1:0] cpu_rd_addr = '0;
   logic                 ev_req_valid = 1'b0;
   logic                 ev_req_ready;
   logic [SET_W-1:0]     ev_set = '0;
   logic [WAY_W-1:0]     ev_way = '0;
   logic                 ev_data_valid;
   logic                 ev_data_ready = 1'b0;
   logic [LINE_W-1:0]    ev_data;
   logic [RD_ADDR_W-1:0] bram_rd_addr;
   logic [WR_ADDR_W-1:0] bram_wr_addr;
   logic [QW-1:0]        bram_wr_data;
   logic                 bram_wr_en;
   logic [LINE_W-1:0]    bram_data_out;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   data_array_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_set(fill_set),
      .fill_way(fill_way), .fill_data(fill_data), .fill_done(fill_done),
      .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
      .cpu_rd_valid(cpu_rd_valid), .cpu_rd_ready(cpu_rd_ready), .cpu_rd_addr(cpu_rd_addr),
      .ev_req_valid(ev_req_valid), .ev_req_ready(ev_req_ready), .ev_set(ev_set),
      .ev_way(ev_way), .ev_data_valid(ev_data_valid), .ev_data_ready(ev_data_ready),
      .ev_data(ev_data), .bram_rd_addr(bram_rd_addr), .bram_wr_addr(bram_wr_addr),
      .bram_wr_data(bram_wr_data), .bram_wr_en(bram_wr_en), .bram_data_out(bram_data_out)
   );

   // Blockram model: 4096 quarters addressed {set,q,way}, registered read of all 4 ways.
   quarter_t mem [0:4095];
   always @(posedge clk) begin
      if (bram_wr_en) mem[bram_wr_addr] <= bram_wr_data;
      for (int w = 0; w < 4; w++)
         bram_data_out[w*QW +: QW] <= mem[{bram_rd_addr, 2'(w)}];
   end

   // Reference contents of every line, indexed set*4+way.
   line_t ref_line [0:1023];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, limit 200000 expected end");
      $fatal(1);
   end

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic check_val(input string tag, input line_t obs, input line_t exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [11:0] exp_wr(int s, int q, int w);
      return 12'(s*16 + q*4 + w);
   endfunction

   function automatic logic [9:0] exp_rd(int s, int q);
      return 10'(s*4 + q);
   endfunction

   function automatic line_t rand_line();
      line_t l;
      for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   function automatic quarter_t rand_quarter();
      quarter_t d;
      for (int i = 0; i < 4; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic ref_store(input logic [11:0] a, input quarter_t d);
      int idx;
      int q;
      line_t l;
      idx = int'(a[11:4])*4 + int'(a[1:0]);
      q   = int'(a[3:2]);
      l   = ref_line[idx];
      l[q*QW +: QW] = d;
      ref_line[idx] = l;
   endtask

   // Full fill: handshake, then four quarter writes with fill_done on the last.
   task automatic do_fill(input int s, input int w, input line_t d);
      fill_valid = 1'b1; fill_set = 8'(s); fill_way = 2'(w); fill_data = d;
      #1;
      check_bit("fill_ready_idle", fill_ready, 1'b1);
      tick();
      fill_valid = 1'b0; fill_data = '0;
      for (int q = 0; q < 4; q++) begin
         #1;
         check_bit("fill_wr_en", bram_wr_en, 1'b1);
         check_val("fill_wr_addr", line_t'(bram_wr_addr), line_t'(exp_wr(s, q, w)));
         check_val("fill_wr_data", line_t'(bram_wr_data), line_t'(d[q*QW +: QW]));
         check_bit("fill_done", fill_done, q == 3);
         check_bit("fill_ready_busy", fill_ready, 1'b0);
         tick();
      end
      ref_line[s*4 + w] = d;
   endtask

   // Evict with immediate consumer: read addresses, then line vs reference.
   task automatic run_evict(input int s, input int w);
      line_t exp_line;
      ev_req_valid = 1'b1; ev_set = 8'(s); ev_way = 2'(w);
      #1;
      check_bit("ev_req_ready", ev_req_ready, 1'b1);
      exp_line = ref_line[s*4 + w];
      tick();
      ev_req_valid = 1'b0;
      for (int q = 0; q < 4; q++) begin
         #1;
         check_val("ev_rd_addr", line_t'(bram_rd_addr), line_t'(exp_rd(s, q)));
         tick();
      end
      #1;
      check_bit("ev_wait_valid", ev_data_valid, 1'b0);
      tick();
      ev_data_ready = 1'b1;
      #1;
      check_bit("ev_out_valid", ev_data_valid, 1'b1);
      check_val("ev_line", ev_data, exp_line);
      tick();
      ev_data_ready = 1'b0;
   endtask

   initial begin
      int s2, w2;
      logic [11:0] sa;
      quarter_t sd;
      line_t exp_line, d2;

      // ---- reset state ----
      tick(); tick(); #1;
      check_bit("rst_fill_ready", fill_ready, 1'b1);
      check_bit("rst_ev_req_ready", ev_req_ready, 1'b1);
      check_bit("rst_fill_done", fill_done, 1'b0);
      check_bit("rst_st_ready", st_ready, 1'b0);
      check_bit("rst_cpu_rd_ready", cpu_rd_ready, 1'b0);
      check_bit("rst_ev_data_valid", ev_data_valid, 1'b0);
      check_bit("rst_wr_en", bram_wr_en, 1'b0);
      check_val("rst_wr_addr", line_t'(bram_wr_addr), '0);
      check_val("rst_wr_data", line_t'(bram_wr_data), '0);
      check_val("rst_rd_addr", line_t'(bram_rd_addr), '0);
      check_val("rst_ev_data", ev_data, '0);
      rst_n = 1'b1;
      tick();

      // ---- fill set 0x12 way 2 ----
      do_fill(8'h12, 2, rand_line());

      // ---- fill and store tie: fill first, store 5 cycles later ----
      s2 = int'($urandom_range(255)); w2 = int'($urandom_range(3));
      sa = exp_wr(s2, int'($urandom_range(3)), w2);
      sd = rand_quarter();
      d2 = rand_line();
      fill_valid = 1'b1; fill_set = 8'(s2); fill_way = 2'(w2); fill_data = d2;
      st_valid = 1'b1; st_addr = sa; st_data = sd;
      #1;
      check_bit("tie_fill_ready", fill_ready, 1'b1);
      check_bit("tie_st_ready", st_ready, 1'b0);
      tick();
      fill_valid = 1'b0;
      for (int q = 0; q < 4; q++) begin
         #1;
         check_bit("tie_st_blocked", st_ready, 1'b0);
         check_val("tie_fill_addr", line_t'(bram_wr_addr), line_t'(exp_wr(s2, q, w2)));
         tick();
      end
      #1;
      check_bit("tie_st_ready_after", st_ready, 1'b1);
      check_bit("tie_st_wr_en", bram_wr_en, 1'b1);
      check_val("tie_st_addr", line_t'(bram_wr_addr), line_t'(sa));
      check_val("tie_st_data", line_t'(bram_wr_data), line_t'(sd));
      ref_line[s2*4 + w2] = d2;
      ref_store(sa, sd);
      tick();
      st_valid = 1'b0;

      // ---- evict set 5 way 1 with port contention, held output ----
      do_fill(5, 1, rand_line());
      ev_req_valid = 1'b1; ev_set = 8'd5; ev_way = 2'd1;
      #1;
      check_bit("ev5_req_ready", ev_req_ready, 1'b1);
      exp_line = ref_line[5*4 + 1];
      tick();
      ev_req_valid = 1'b0;
      d2 = rand_line();
      for (int q = 0; q < 4; q++) begin
         cpu_rd_valid = 1'b1; cpu_rd_addr = 10'($urandom);
         st_valid = 1'b0;
         if (q == 1) begin st_valid = 1'b1; st_addr = exp_wr(5, 1, 1); st_data = rand_quarter(); end
         if (q == 2) begin st_valid = 1'b1; st_addr = exp_wr(5, 1, 0); st_data = rand_quarter(); end
         if (q == 3) begin fill_valid = 1'b1; fill_set = 8'd5; fill_way = 2'd1; fill_data = d2; end
         #1;
         check_val("ev5_rd_addr", line_t'(bram_rd_addr), line_t'(exp_rd(5, q)));
         check_bit("ev5_cpu_rd_ready", cpu_rd_ready, 1'b0);
         check_bit("ev5_req_ready_busy", ev_req_ready, 1'b0);
         check_bit("ev5_valid_early", ev_data_valid, 1'b0);
         if (q == 1) check_bit("ev5_st_same_line", st_ready, 1'b0);
         if (q == 2) begin
            check_bit("ev5_st_other_way", st_ready, 1'b1);
            check_bit("ev5_st_other_wr_en", bram_wr_en, 1'b1);
            ref_store(st_addr, st_data);
         end
         if (q == 3) check_bit("ev5_fill_blocked_rd", fill_ready, 1'b0);
         tick();
      end
      st_valid = 1'b0;
      #1;
      check_bit("ev5_wait_fill_blocked", fill_ready, 1'b0);
      check_bit("ev5_wait_cpu_rd_ready", cpu_rd_ready, 1'b1);
      check_val("ev5_wait_rd_addr", line_t'(bram_rd_addr), line_t'(cpu_rd_addr));
      check_bit("ev5_wait_valid", ev_data_valid, 1'b0);
      tick();
      cpu_rd_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         check_bit("ev5_out_valid", ev_data_valid, 1'b1);
         check_val("ev5_out_stable", ev_data, exp_line);
         check_bit("ev5_out_req_ready", ev_req_ready, 1'b0);
         if (i == 0) check_bit("ev5_out_fill_ready", fill_ready, 1'b1);
         if (i >= 1 && i <= 4)
            check_val("ev5_out_fill_addr", line_t'(bram_wr_addr), line_t'(exp_wr(5, i-1, 1)));
         tick();
         if (i == 0) fill_valid = 1'b0;
      end
      ref_line[5*4 + 1] = d2;
      ev_data_ready = 1'b1;
      #1;
      check_bit("ev5_take_valid", ev_data_valid, 1'b1);
      tick();
      ev_data_ready = 1'b0;
      #1;
      check_bit("ev5_done_valid", ev_data_valid, 1'b0);
      check_bit("ev5_done_req_ready", ev_req_ready, 1'b1);

      // ---- evict and fill same line in idle: evict wins ----
      d2 = rand_line();
      ev_req_valid = 1'b1; ev_set = 8'd5; ev_way = 2'd1;
      fill_valid = 1'b1; fill_set = 8'd5; fill_way = 2'd1; fill_data = d2;
      #1;
      check_bit("evtie_fill_ready", fill_ready, 1'b0);
      check_bit("evtie_ev_req_ready", ev_req_ready, 1'b1);
      exp_line = ref_line[5*4 + 1];
      tick();
      ev_req_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check_bit("evtie_fill_waits", fill_ready, 1'b0);
         tick();
      end
      ev_data_ready = 1'b1;
      #1;
      check_bit("evtie_fill_ready_out", fill_ready, 1'b1);
      check_val("evtie_line", ev_data, exp_line);
      tick();
      fill_valid = 1'b0; ev_data_ready = 1'b0;
      for (int q = 0; q < 4; q++) begin
         #1;
         check_val("evtie_fill_addr", line_t'(bram_wr_addr), line_t'(exp_wr(5, q, 1)));
         check_bit("evtie_fill_done", fill_done, q == 3);
         tick();
      end
      ref_line[5*4 + 1] = d2;

      // ---- random fill / store / evict rounds ----
      for (int r = 0; r < 6; r++) begin
         int s, w;
         s = int'($urandom_range(255)); w = int'($urandom_range(3));
         do_fill(s, w, rand_line());
         st_valid = 1'b1;
         st_addr = exp_wr(s, int'($urandom_range(3)), w);
         st_data = rand_quarter();
         #1;
         check_bit("rnd_st_ready", st_ready, 1'b1);
         ref_store(st_addr, st_data);
         tick();
         st_valid = 1'b0;
         run_evict(s, w);
      end
      run_evict(s2, w2);
      run_evict(8'h12, 2);

      // ---- reset during fill quarter 1 ----
      fill_valid = 1'b1; fill_set = 8'($urandom); fill_way = 2'($urandom); fill_data = rand_line();
      #1;
      tick();
      fill_valid = 1'b0;
      #1;
      check_bit("abort_q0_wr_en", bram_wr_en, 1'b1);
      tick();
      #1;
      check_bit("abort_q1_wr_en", bram_wr_en, 1'b1);
      rst_n = 1'b0;
      #1;
      check_bit("abort_wr_en", bram_wr_en, 1'b0);
      check_bit("abort_fill_ready", fill_ready, 1'b1);
      check_bit("abort_fill_done", fill_done, 1'b0);
      check_bit("abort_ev_req_ready", ev_req_ready, 1'b1);
      check_val("abort_ev_data", ev_data, '0);
      tick(); tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check_bit("abort_no_write", bram_wr_en, 1'b0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
